pwm: RTL and testbench

- Single-channel, edge-aligned PWM generator with 32-bit period and compare inputs.
- Period and compare are sampled into shadow registers only at period boundaries, so the output is glitch-free.
- `pwm_fetch` pulses once per period to tell the upstream supplier that new settings have been taken and the next ones may be presented.
- Used as a leaf block driving actuator enables; the controller updates duty through `pwm_peirod` / `pwm_compare`.

---
 rtl/pwm_pkg.sv | 4 +
 rtl/pwm.sv | 54 +++++
 tb/tb_pwm.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared constants for the pwm block.
package pwm_pkg;
   localparam int unsigned PWM_WIDTH = 32;
endpackage

// File: rtl/pwm.sv
// Edge-aligned single-channel PWM. Period and compare are shadowed only at period boundaries.
module pwm
   import pwm_pkg::*;
#(
   parameter int unsigned WIDTH = PWM_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] pwm_peirod,
   input  logic [WIDTH-1:0] pwm_compare,
   output logic             pwm_pulse,
   output logic             pwm_fetch
);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] ap_q,  ap_d;
   logic [WIDTH-1:0] ac_q,  ac_d;
   logic             pulse_d;
   logic             fetch_d;
   logic             load;

   // A zero period reloads every cycle so a disabled channel picks up new settings at once.
   always_comb begin
      load    = (ap_q == '0) || (cnt_q == ap_q - WIDTH'(1));
      cnt_d   = cnt_q + WIDTH'(1);
      ap_d    = ap_q;
      ac_d    = ac_q;
      fetch_d = 1'b0;
      if (load) begin
         cnt_d   = '0;
         ap_d    = pwm_peirod;
         ac_d    = pwm_compare;
         fetch_d = 1'b1;
      end
      pulse_d = (ap_d != '0) && (cnt_d < ac_d);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q     <= '0;
         ap_q      <= '0;
         ac_q      <= '0;
         pwm_pulse <= 1'b0;
         pwm_fetch <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         ap_q      <= ap_d;
         ac_q      <= ac_d;
         pwm_pulse <= pulse_d;
         pwm_fetch <= fetch_d;
      end
   end

endmodule

// File: tb/tb_pwm.sv
// Self-checking bench for pwm: directed vector table, randomized run against a waveform model, and a long-period check.
module tb_pwm;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] pwm_peirod;
   logic [31:0] pwm_compare;
   logic        pwm_pulse;
   logic        pwm_fetch;

   logic        rst16;
   logic [15:0] per16;
   logic [15:0] cmp16;
   logic        pulse16;
   logic        fetch16;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   pwm #(.WIDTH(32)) u_dut (
      .clock       (clock),
      .reset       (reset),
      .pwm_peirod  (pwm_peirod),
      .pwm_compare (pwm_compare),
      .pwm_pulse   (pwm_pulse),
      .pwm_fetch   (pwm_fetch)
   );

   pwm #(.WIDTH(16)) u_dut16 (
      .clock       (clock),
      .reset       (rst16),
      .pwm_peirod  (per16),
      .pwm_compare (cmp16),
      .pwm_pulse   (pulse16),
      .pwm_fetch   (fetch16)
   );

   typedef struct {
      logic        rst;
      logic [31:0] per;
      logic [31:0] cmp;
      logic        p;
      logic        f;
   } vec_t;

   typedef struct {
      logic p;
      logic f;
   } out_t;

   vec_t vq[$];
   out_t wave[$];

   function automatic void add(input logic r, input logic [31:0] pr, input logic [31:0] cm,
                               input logic p, input logic f);
      vec_t v;
      v.rst = r; v.per = pr; v.cmp = cm; v.p = p; v.f = f;
      vq.push_back(v);
   endfunction

   function automatic void chk(input string nm, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
      end
   endfunction

   // Model: each load emits the whole period's waveform into a queue; the next load happens when it drains.
   task automatic cycle(input logic r, input logic [31:0] pr, input logic [31:0] cm,
                        input bit has, input logic ep, input logic ef, input string nm);
      out_t o;
      reset       = r;
      pwm_peirod  = pr;
      pwm_compare = cm;
      if (r) begin
         wave.delete();
         o.p = 1'b0; o.f = 1'b0;
      end else begin
         if (wave.size() == 0) begin
            if (pr == 32'd0) begin
               o.p = 1'b0; o.f = 1'b1;
               wave.push_back(o);
            end else begin
               for (int unsigned i = 0; i < pr; i++) begin
                  o.p = (32'(i) < cm);
                  o.f = (i == 0);
                  wave.push_back(o);
               end
            end
         end
         o = wave.pop_front();
      end
      @(posedge clock);
      #1;
      chk({nm, ".model.pulse"}, pwm_pulse, o.p);
      chk({nm, ".model.fetch"}, pwm_fetch, o.f);
      if (has) begin
         chk({nm, ".table.pulse"}, pwm_pulse, ep);
         chk({nm, ".table.fetch"}, pwm_fetch, ef);
      end
   endtask

   initial begin
      int unsigned cl[3];
      logic [31:0] rp, rc;
      int hi;

      reset = 1'b1; pwm_peirod = '0; pwm_compare = '0;
      rst16 = 1'b1; per16 = '0; cmp16 = '0;

      // Period 4 / compare 2 after a one-cycle reset.
      add(1, 4, 2, 0, 0);
      for (int i = 0; i < 8; i++) add(0, 4, 2, (i % 4) < 2, (i % 4) == 0);
      // Compare raised from 1 to 3 once cnt has reached 1.
      add(1, 4, 1, 0, 0);
      add(0, 4, 1, 1, 1); add(0, 4, 1, 0, 0);
      add(0, 4, 3, 0, 0); add(0, 4, 3, 0, 0);
      add(0, 4, 3, 1, 1); add(0, 4, 3, 1, 0); add(0, 4, 3, 1, 0); add(0, 4, 3, 0, 0);
      // Period 5 with compare 0, 5 and 9.
      cl[0] = 0; cl[1] = 5; cl[2] = 9;
      for (int k = 0; k < 3; k++) begin
         add(1, 5, cl[k], 0, 0);
         for (int i = 0; i < 10; i++) add(0, 5, cl[k], cl[k] != 0, (i % 5) == 0);
      end
      // Disabled channel, then period 1 with compare 1.
      add(1, 0, 7, 0, 0);
      for (int i = 0; i < 4; i++) add(0, 0, 7, 0, 1);
      for (int i = 0; i < 4; i++) add(0, 1, 1, 1, 1);
      // Reset asserted at cnt=4 of a period-6 run, held two cycles.
      add(1, 6, 3, 0, 0);
      for (int i = 0; i < 5; i++) add(0, 6, 3, i < 3, i == 0);
      add(1, 6, 3, 0, 0); add(1, 6, 3, 0, 0);
      for (int i = 0; i < 7; i++) add(0, 6, 3, (i % 6) < 3, (i % 6) == 0);

      foreach (vq[i]) cycle(vq[i].rst, vq[i].per, vq[i].cmp, 1'b1, vq[i].p, vq[i].f, $sformatf("vec%0d", i));

      // Randomized settings changing every cycle; only values present at load edges matter.
      for (int i = 0; i < 3000; i++) begin
         rp = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : 32'($urandom_range(3, 20));
         case ($urandom_range(0, 3))
            0:       rc = 32'd0;
            1:       rc = $urandom();
            default: rc = 32'($urandom_range(0, 22));
         endcase
         cycle($urandom_range(0, 99) == 0, rp, rc, 1'b0, 1'b0, 1'b0, "rand");
      end

      // Near-maximum period on a 16-bit instance: high for exactly 2^15 cycles after load.
      per16 = 16'hFFFF; cmp16 = 16'h8000; rst16 = 1'b1;
      repeat (2) @(posedge clock);
      #1 rst16 = 1'b0;
      @(posedge clock); #1;
      chk("big.first_fetch", fetch16, 1'b1);
      chk("big.first_pulse", pulse16, 1'b1);
      hi = 1;
      while (pulse16 === 1'b1 && hi < 40000) begin
         @(posedge clock); #1;
         if (pulse16 === 1'b1) hi++;
      end
      n_cmp++;
      if (hi != 32768) begin
         n_err++;
         $display("FAIL big.high_len: got %0d expected %0d", hi, 32768);
      end
      chk("big.fall_fetch", fetch16, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
